// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined middle-bits multiplier: the operand
// limb-count derivation and the slice-select encoding.
package mul_pkg;

    // Slice select: MID returns P[2*RADIX-1:RADIX], LOW returns P[RADIX-1:0].
    localparam logic MODE_MID = 1'b0;
    localparam logic MODE_LOW = 1'b1;

    // Number of LIMB-wide tiles needed to cover an n-bit operand.
    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/multiplier_middle_bits_pipe_if.sv
// Request/response bundle of the middle-bits multiplier.
//
// Handshake: both channels use valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both 1. A source holding valid=1 keeps
// its payload stable until that transfer; ready may depend combinationally on
// the sink's state but never on the same channel's valid.
interface multiplier_middle_bits_pipe_if #(
    parameter int MUL_SIZE = 56,
    parameter int RADIX    = 54,
    parameter int TAG_W    = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [MUL_SIZE-1:0] a;
    logic [MUL_SIZE-1:0] b;
    logic                mode;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [RADIX-1:0]    res;
    logic [TAG_W-1:0]    out_tag;

    // Upstream issuer / downstream consumer side.
    modport master (
        output in_valid, a, b, mode, in_tag, out_ready,
        input  in_ready, out_valid, res, out_tag
    );

    // Multiplier side.
    modport slave (
        input  in_valid, a, b, mode, in_tag, out_ready,
        output in_ready, out_valid, res, out_tag
    );

endinterface

// File: rtl/mul_row_accum.sv
// One row of the limb multiplier: the NL tile products of one A limb against
// every B limb (stage 2) and their shifted sum (stage 3). Both registers hold
// while en_i is low so the whole pipeline stalls as one.
module mul_row_accum #(
    parameter int LIMB = 18,
    parameter int NL   = 4,
    parameter int ROW  = 0
) (
    input  logic                   clk,
    input  logic                   en_i,
    input  logic [LIMB-1:0]        a_limb_i,
    input  logic [NL*LIMB-1:0]     b_i,
    output logic [2*NL*LIMB-1:0]   row_o
);
    localparam int PW = 2 * LIMB;
    localparam int RW = 2 * NL * LIMB;

    logic [PW-1:0] pp_q [NL];
    logic [RW-1:0] row_d;
    logic [RW-1:0] row_q;

    // Stage 2: one tile product per B limb.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int j = 0; j < NL; j++) begin
                pp_q[j] <= PW'(a_limb_i) * PW'(b_i[j*LIMB +: LIMB]);
            end
        end
    end

    // Place each product at its limb weight LIMB*(ROW+j) and add them up.
    always_comb begin
        row_d = '0;
        for (int j = 0; j < NL; j++) begin
            row_d = row_d + (RW'(pp_q[j]) << (LIMB * (ROW + j)));
        end
    end

    // Stage 3: register the row sum.
    always_ff @(posedge clk) begin
        if (en_i) begin
            row_q <= row_d;
        end
    end

    assign row_o = row_q;

endmodule

// File: rtl/multiplier_middle_bits_pipe.sv
// Four-stage pipelined unsigned multiplier returning a RADIX-bit slice of the
// product (middle or low, chosen per operation). One operation per cycle, a
// single global stall driven by the output stage, user tag carried alongside.
module multiplier_middle_bits_pipe
    import mul_pkg::*;
#(
    parameter int MUL_SIZE = 56,
    parameter int RADIX    = 54,
    parameter int LIMB     = 18,
    parameter int TAG_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    multiplier_middle_bits_pipe_if.slave bus
);
    localparam int NL = ceil_div(MUL_SIZE, LIMB);
    localparam int W  = NL * LIMB;
    localparam int RW = 2 * W;

    // Valid chain and stall.
    logic advance;
    logic v1_q, v2_q, v3_q, v4_q;

    // Stage 1: zero-padded operands plus sideband.
    logic [W-1:0]     a1_q, b1_q;
    logic             mode1_q, mode2_q, mode3_q;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;

    // Stage 3 row sums from the row units.
    logic [RW-1:0] rows [NL];

    // Stage 4 combine and output registers.
    logic [RW-1:0]    prod_d;
    logic [RW-1:0]    shifted_d;
    logic [RADIX-1:0] res_d;
    logic [RADIX-1:0] res_q;
    logic [TAG_W-1:0] tag4_q;

    // The pipeline moves only when the output register is empty or draining.
    assign advance      = ~v4_q | bus.out_ready;
    assign bus.in_ready = advance & ~rst;
    assign bus.out_valid = v4_q;
    assign bus.res       = res_q;
    assign bus.out_tag   = tag4_q;

    // Valid bits and output registers: cleared by reset, shifted on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            v4_q   <= 1'b0;
            res_q  <= '0;
            tag4_q <= '0;
        end else if (advance) begin
            v1_q   <= bus.in_valid;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            v4_q   <= v3_q;
            res_q  <= res_d;
            tag4_q <= tag3_q;
        end
    end

    // Operand capture and sideband delay line; contents under a clear valid
    // bit are don't-care, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (advance) begin
            a1_q    <= W'(bus.a);
            b1_q    <= W'(bus.b);
            mode1_q <= bus.mode;
            tag1_q  <= bus.in_tag;
            mode2_q <= mode1_q;
            tag2_q  <= tag1_q;
            mode3_q <= mode2_q;
            tag3_q  <= tag2_q;
        end
    end

    // One row unit per A limb (stages 2 and 3).
    for (genvar g = 0; g < NL; g++) begin : g_row
        mul_row_accum #(
            .LIMB (LIMB),
            .NL   (NL),
            .ROW  (g)
        ) u_row (
            .clk      (clk),
            .en_i     (advance),
            .a_limb_i (a1_q[g*LIMB +: LIMB]),
            .b_i      (b1_q),
            .row_o    (rows[g])
        );
    end

    // Sum the rows into the full product and pick the slice. The product of
    // two MUL_SIZE-bit values never exceeds 2*MUL_SIZE bits, so the padded
    // upper bits are always zero and no explicit truncation is needed.
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < NL; i++) begin
            prod_d = prod_d + rows[i];
        end
        shifted_d = (mode3_q == MODE_MID) ? (prod_d >> RADIX) : prod_d;
        res_d     = RADIX'(shifted_d);
    end

endmodule

// File: tb/tb_multiplier_middle_bits_pipe.sv
// Bench for the pipelined middle-bits multiplier: default 56/54/18 build plus
// two alternate parameter sets driven side by side.
module tb_multiplier_middle_bits_pipe;
    import mul_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    int retired0, retired1, retired2;
    logic [127:0] exp0_res_q[$];
    logic [3:0]   exp0_tag_q[$];
    logic [127:0] exp1_res_q[$];
    logic [3:0]   exp1_tag_q[$];
    logic [127:0] exp2_res_q[$];
    logic [3:0]   exp2_tag_q[$];

    multiplier_middle_bits_pipe_if #(.MUL_SIZE(56), .RADIX(54), .TAG_W(4)) bus0 ();
    multiplier_middle_bits_pipe_if #(.MUL_SIZE(34), .RADIX(32), .TAG_W(4)) bus1 ();
    multiplier_middle_bits_pipe_if #(.MUL_SIZE(64), .RADIX(60), .TAG_W(4)) bus2 ();

    multiplier_middle_bits_pipe #(.MUL_SIZE(56), .RADIX(54), .LIMB(18), .TAG_W(4)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0));
    multiplier_middle_bits_pipe #(.MUL_SIZE(34), .RADIX(32), .LIMB(17), .TAG_W(4)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1));
    multiplier_middle_bits_pipe #(.MUL_SIZE(64), .RADIX(60), .LIMB(18), .TAG_W(4)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact product, keep 2m bits, then take the requested slice.
    function automatic logic [127:0] ref_slice(input logic [63:0] a, input logic [63:0] b,
                                               input logic mode, input int m, input int r);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        p = p & ((128'd1 << (2 * m)) - 128'd1);
        if (mode == MODE_MID) p = p >> r;
        p = p & ((128'd1 << r) - 128'd1);
        return p;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // ---------------- scoreboards ----------------
    task automatic monitor0();
        logic         held;
        logic [53:0]  held_res;
        logic [3:0]   held_tag;
        logic [127:0] e;
        logic [3:0]   et;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp0_res_q.delete();
                exp0_tag_q.delete();
                held = 1'b0;
                checks++;
                if (bus0.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL in_ready_in_reset got=%b want=0", bus0.in_ready);
                end
            end else begin
                checks++;
                if (bus0.in_ready !== !(bus0.out_valid && !bus0.out_ready)) begin
                    failures++;
                    $display("FAIL in_ready_rule got=%b out_valid=%b out_ready=%b",
                             bus0.in_ready, bus0.out_valid, bus0.out_ready);
                end
                if (held) begin
                    checks++;
                    if (bus0.out_valid !== 1'b1 || bus0.res !== held_res || bus0.out_tag !== held_tag) begin
                        failures++;
                        $display("FAIL hold_stable got v=%b res=%h tag=%h want v=1 res=%h tag=%h",
                                 bus0.out_valid, bus0.res, bus0.out_tag, held_res, held_tag);
                    end
                end
                if (bus0.in_valid && bus0.in_ready) begin
                    exp0_res_q.push_back(ref_slice(64'(bus0.a), 64'(bus0.b), bus0.mode, 56, 54));
                    exp0_tag_q.push_back(bus0.in_tag);
                end
                held = 1'b0;
                if (bus0.out_valid === 1'b1) begin
                    if (bus0.out_ready) begin
                        checks++;
                        if (exp0_res_q.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_out0 got res=%h tag=%h want none", bus0.res, bus0.out_tag);
                        end else begin
                            e  = exp0_res_q.pop_front();
                            et = exp0_tag_q.pop_front();
                            retired0++;
                            if (bus0.res !== e[53:0] || bus0.out_tag !== et) begin
                                failures++;
                                $display("FAIL result0 got res=%h tag=%h want res=%h tag=%h",
                                         bus0.res, bus0.out_tag, e[53:0], et);
                            end
                        end
                    end else begin
                        held     = 1'b1;
                        held_res = bus0.res;
                        held_tag = bus0.out_tag;
                    end
                end
            end
        end
    endtask

    task automatic monitor1();
        logic [127:0] e;
        logic [3:0]   et;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp1_res_q.delete();
                exp1_tag_q.delete();
            end else begin
                if (bus1.in_valid && bus1.in_ready) begin
                    exp1_res_q.push_back(ref_slice(64'(bus1.a), 64'(bus1.b), bus1.mode, 34, 32));
                    exp1_tag_q.push_back(bus1.in_tag);
                end
                if (bus1.out_valid === 1'b1 && bus1.out_ready) begin
                    checks++;
                    if (exp1_res_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_out1 got res=%h want none", bus1.res);
                    end else begin
                        e  = exp1_res_q.pop_front();
                        et = exp1_tag_q.pop_front();
                        retired1++;
                        if (bus1.res !== e[31:0] || bus1.out_tag !== et) begin
                            failures++;
                            $display("FAIL result1 got res=%h tag=%h want res=%h tag=%h",
                                     bus1.res, bus1.out_tag, e[31:0], et);
                        end
                    end
                end
            end
        end
    endtask

    task automatic monitor2();
        logic [127:0] e;
        logic [3:0]   et;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp2_res_q.delete();
                exp2_tag_q.delete();
            end else begin
                if (bus2.in_valid && bus2.in_ready) begin
                    exp2_res_q.push_back(ref_slice(bus2.a, bus2.b, bus2.mode, 64, 60));
                    exp2_tag_q.push_back(bus2.in_tag);
                end
                if (bus2.out_valid === 1'b1 && bus2.out_ready) begin
                    checks++;
                    if (exp2_res_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_out2 got res=%h want none", bus2.res);
                    end else begin
                        e  = exp2_res_q.pop_front();
                        et = exp2_tag_q.pop_front();
                        retired2++;
                        if (bus2.res !== e[59:0] || bus2.out_tag !== et) begin
                            failures++;
                            $display("FAIL result2 got res=%h tag=%h want res=%h tag=%h",
                                     bus2.res, bus2.out_tag, e[59:0], et);
                        end
                    end
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    // Issue one op on bus0 and return cycles until out_valid (-1 on timeout).
    task automatic issue_and_wait0(input logic [55:0] a, input logic [55:0] b,
                                   input logic mode, input logic [3:0] tag, output int lat);
        @(posedge clk);
        #1;
        bus0.a = a; bus0.b = b; bus0.mode = mode; bus0.in_tag = tag;
        bus0.in_valid = 1'b1;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            bus0.in_valid = 1'b0;
            @(negedge clk);
            if (bus0.out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.res !== '0 || bus0.out_tag !== '0) begin
            failures++;
            $display("FAIL reset_state got v=%b res=%h tag=%h want 0 0 0", bus0.out_valid, bus0.res, bus0.out_tag);
        end
        checks++;
        if (bus0.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want=0", bus0.in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got=%b want=1", bus0.in_ready);
        end
    endtask

    task automatic test_mid_one();
        int lat;
        issue_and_wait0(56'd1 << 54, 56'd1, MODE_MID, 4'hA, lat);
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL mid_one_latency got=%0d want=4", lat);
        end
        checks++;
        if (bus0.res !== 54'd1 || bus0.out_tag !== 4'hA) begin
            failures++;
            $display("FAIL mid_one got res=%h tag=%h want res=1 tag=a", bus0.res, bus0.out_tag);
        end
    endtask

    task automatic test_all_ones();
        int lat;
        logic [55:0] ones;
        ones = '1;
        issue_and_wait0(ones, ones, MODE_MID, 4'h3, lat);
        checks++;
        if (lat != 4 || bus0.res !== 54'h3FFFFFFFFFFFF8) begin
            failures++;
            $display("FAIL all_ones_mid got lat=%0d res=%h want lat=4 res=3ffffffffffff8", lat, bus0.res);
        end
        issue_and_wait0(ones, ones, MODE_LOW, 4'h5, lat);
        checks++;
        if (lat != 4 || bus0.res !== 54'd1 || bus0.out_tag !== 4'h5) begin
            failures++;
            $display("FAIL all_ones_low got lat=%0d res=%h tag=%h want lat=4 res=1 tag=5", lat, bus0.res, bus0.out_tag);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ra, rb;
        bus0.out_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            @(posedge clk);
            #1;
            if (c < 16) begin
                ra = rand64(); rb = rand64();
                bus0.a = ra[55:0]; bus0.b = rb[55:0];
                bus0.mode = c[0];
                bus0.in_tag = c[3:0];
                bus0.in_valid = 1'b1;
            end else begin
                bus0.in_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (bus0.out_valid !== (c >= 4 && c < 20)) begin
                failures++;
                $display("FAIL b2b_valid cycle=%0d got=%b want=%b", c, bus0.out_valid, (c >= 4 && c < 20));
            end else if (c >= 4 && c < 20) begin
                checks++;
                if (bus0.out_tag !== 4'(c - 4)) begin
                    failures++;
                    $display("FAIL b2b_order cycle=%0d got tag=%h want tag=%h", c, bus0.out_tag, 4'(c - 4));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int idx;
        int start;
        int stalls;
        bit done;
        logic [63:0] ra, rb;
        idx = 0; stalls = 0; done = 0;
        start = retired0;
        ra = rand64(); rb = rand64();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (idx == 16 && exp0_res_q.size() == 0) begin
                done = 1;
                break;
            end
            bus0.out_ready = ($urandom_range(0, 9) >= 3);
            if (idx < 16) begin
                bus0.a = ra[55:0]; bus0.b = rb[55:0];
                bus0.mode = idx[0];
                bus0.in_tag = idx[3:0];
                bus0.in_valid = 1'b1;
            end else begin
                bus0.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus0.out_valid && !bus0.out_ready) stalls++;
            if (bus0.in_valid && bus0.in_ready) begin
                idx++;
                ra = rand64(); rb = rand64();
            end
        end
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b1;
        checks++;
        if (!done || retired0 - start != 16) begin
            failures++;
            $display("FAIL backpressure_drain got done=%0d retired=%0d want done=1 retired=16", done, retired0 - start);
        end
        checks++;
        if (stalls == 0) begin
            failures++;
            $display("FAIL backpressure_exercised got stalls=0 want >0");
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        logic [63:0] ra, rb;
        logic [127:0] e;
        bus0.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            ra = rand64(); rb = rand64();
            bus0.a = ra[55:0]; bus0.b = rb[55:0];
            bus0.mode = c[0]; bus0.in_tag = 4'(8 + c);
            bus0.in_valid = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus0.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midflight_in_ready got=%b want=0", bus0.in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.res !== '0) begin
            failures++;
            $display("FAIL midflight_cleared got v=%b res=%h want v=0 res=0", bus0.out_valid, bus0.res);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (bus0.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL midflight_ghost cycle=%0d got v=%b want v=0", c, bus0.out_valid);
            end
        end
        ra = rand64(); rb = rand64();
        e = ref_slice({8'd0, ra[55:0]}, {8'd0, rb[55:0]}, MODE_LOW, 56, 54);
        issue_and_wait0(ra[55:0], rb[55:0], MODE_LOW, 4'hE, lat);
        checks++;
        if (lat != 4 || bus0.res !== e[53:0] || bus0.out_tag !== 4'hE) begin
            failures++;
            $display("FAIL after_reset_op got lat=%0d res=%h tag=%h want lat=4 res=%h tag=e",
                     lat, bus0.res, bus0.out_tag, e[53:0]);
        end
    endtask

    task automatic test_sweep();
        logic [63:0] ra, rb;
        int s1, s2;
        bit done;
        s1 = retired1; s2 = retired2; done = 0;
        bus1.out_ready = 1'b1;
        bus2.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            ra = (c < 2) ? '1 : rand64();
            rb = (c < 2) ? '1 : rand64();
            bus1.a = ra[33:0]; bus1.b = rb[33:0]; bus1.mode = c[0]; bus1.in_tag = c[3:0];
            bus2.a = ra;       bus2.b = rb;       bus2.mode = c[0]; bus2.in_tag = c[3:0];
            bus1.in_valid = 1'b1;
            bus2.in_valid = 1'b1;
            @(negedge clk);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            bus1.in_valid = 1'b0;
            bus2.in_valid = 1'b0;
            if (retired1 - s1 == 12 && retired2 - s2 == 12) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!done || exp1_res_q.size() != 0 || exp2_res_q.size() != 0) begin
            failures++;
            $display("FAIL sweep_drain got r34=%0d r64=%0d want 12 12", retired1 - s1, retired2 - s2);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        checks = 0; failures = 0;
        retired0 = 0; retired1 = 0; retired2 = 0;
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.mode = 1'b0; bus0.in_tag = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.mode = 1'b0; bus1.in_tag = '0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.mode = 1'b0; bus2.in_tag = '0; bus2.out_ready = 1'b1;
        fork
            monitor0();
            monitor1();
            monitor2();
        join_none
        test_reset();
        test_mid_one();
        test_all_ones();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_sweep();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
